uart_rx_ctrl: RTL

Receive-side controller for the UART receiver. It generates the 16x oversampling `baud_pulse` from a programmable divisor and captures each completed byte from the receiver into a first-word-fall-through FIFO. It presents those bytes to the core through a valid/ready pop port and reports occupancy, overrun and an interrupt. It sits between the UART receiver and the memory-mapped peripheral register block.

---
 rtl/uart_rx_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: 16x baud tick generator, FWFT receive FIFO, overrun and irq flags.
// Optional idle-timeout flag built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned DIV_WIDTH     = 16,
  parameter int unsigned DIV_RESET     = 53,
  parameter int unsigned IRQ_LEVEL     = 1,
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          div_wr,
  input  logic [DIV_WIDTH-1:0]          div_data,
  output logic                          baud_pulse,
  input  logic                          uart_rx_done,
  input  logic [7:0]                    rx_data,
  output logic                          rd_valid,
  output logic [7:0]                    rd_data,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic                          irq,
  output logic                          rx_timeout
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Elaboration-time parameter sanity checks
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_rx_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((IRQ_LEVEL < 1) || (IRQ_LEVEL > FIFO_DEPTH)) begin : g_bad_irq_level
    $error("uart_rx_ctrl: IRQ_LEVEL out of range");
  end
  if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
    $error("uart_rx_ctrl: TIMEOUT_TICKS must be >= 1");
  end

  logic [DIV_WIDTH-1:0] divisor;
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 full_c;
  logic                 pop_c;
  logic                 push_c;
  logic                 ovr_set_c;

  // Baud generator: a divisor write restarts the period from the write edge
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor    <= DIV_WIDTH'(DIV_RESET);
      baud_cnt   <= '0;
      baud_pulse <= 1'b0;
    end else if (div_wr) begin
      divisor    <= div_data;
      baud_cnt   <= '0;
      baud_pulse <= 1'b0;
    end else if (!enable) begin
      baud_cnt   <= '0;
      baud_pulse <= 1'b0;
    end else if (baud_cnt == divisor) begin
      baud_cnt   <= '0;
      baud_pulse <= 1'b1;
    end else begin
      baud_cnt   <= baud_cnt + DIV_WIDTH'(1);
      baud_pulse <= 1'b0;
    end
  end

  assign full_c    = (fifo_count == CW'(FIFO_DEPTH));
  assign pop_c     = rd_valid & rd_ready;
  assign push_c    = uart_rx_done & enable & (~full_c | pop_c);
  assign ovr_set_c = uart_rx_done & enable & full_c & ~pop_c;

  assign rd_valid  = (fifo_count != '0);
  assign rd_data   = mem[rd_ptr];

  // Storage carries no reset; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      if (push_c && !pop_c)      fifo_count <= fifo_count + CW'(1);
      else if (pop_c && !push_c) fifo_count <= fifo_count - CW'(1);
    end
  end

  // A set event wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst)              overrun <= 1'b0;
    else if (ovr_set_c)   overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] to_cnt;

  // Idle timer runs only while bytes sit unread and nothing moves
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt     <= '0;
      rx_timeout <= 1'b0;
    end else begin
      if (push_c || pop_c || !rd_valid) to_cnt <= '0;
      else if (baud_pulse && (to_cnt != TW'(TIMEOUT_TICKS))) to_cnt <= to_cnt + TW'(1);
      if (pop_c)                               rx_timeout <= 1'b0;
      else if (to_cnt == TW'(TIMEOUT_TICKS))   rx_timeout <= 1'b1;
    end
  end
`else
  assign rx_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= (fifo_count >= CW'(IRQ_LEVEL)) | rx_timeout;
  end

endmodule
